process_scheduler: RTL and testbench

- Round-robin, time-sliced process scheduler for the single-core CPU.
- Keeps a process table (valid bit and saved PC per PID) and counts a quantum while a process runs.
- On quantum expiry, yield syscall or exit, it stalls the CPU, saves the PC, selects the next ready PID and reloads the PC.
- Sits between the CPU's PC register and the OS layer (BIOS/HD loader creates processes); drives the CPU-visible PID used for memory displacement/paging.

---
 rtl/process_scheduler_pkg.sv | 17 +
 rtl/process_scheduler_rr_pid_picker.sv | 24 ++
 rtl/process_scheduler.sv | 100 ++++++++++
 tb/tb_process_scheduler.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/process_scheduler_pkg.sv
// process_scheduler_pkg: shared state encoding, default sizes and process table entry
package process_scheduler_pkg;
  localparam int PS_NUM_PROC = 8;
  localparam int PS_PID_W = 5;
  localparam int PS_PC_W = 32;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_SAVE   = 3'd2,
    ST_SELECT = 3'd3,
    ST_LOAD   = 3'd4
  } state_t;
  typedef struct packed {
    logic                valid;
    logic [PS_PC_W-1:0]  pc;
  } proc_entry_t;
endpackage

// File: rtl/process_scheduler_rr_pid_picker.sv
// rr_pid_picker: rotating-priority search starting after i_last and checking i_last itself last
module rr_pid_picker
  import process_scheduler_pkg::*;
#(
  parameter int NUM_PROC = PS_NUM_PROC,
  parameter int PID_W = PS_PID_W
) (
  input  logic [NUM_PROC-1:0] i_valid,
  input  logic [PID_W-1:0]    i_last,
  output logic                o_found,
  output logic [PID_W-1:0]    o_pid
);
  // walk distances far-to-near so the nearest valid slot after i_last wins
  always_comb begin
    o_found = 1'b0;
    o_pid = '0;
    for (int k = NUM_PROC; k >= 1; k--) begin
      if (i_valid[(int'(i_last) + k) % NUM_PROC]) begin
        o_found = 1'b1;
        o_pid = PID_W'((int'(i_last) + k) % NUM_PROC);
      end
    end
  end
endmodule

// File: rtl/process_scheduler.sv
// process_scheduler: round-robin time-sliced scheduler saving/reloading the CPU PC per process
module process_scheduler
  import process_scheduler_pkg::*;
#(
  parameter int NUM_PROC = PS_NUM_PROC,
  parameter int PID_W = PS_PID_W,
  parameter int PC_W = PS_PC_W,
  parameter int QUANTUM = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_create_en,
  input  logic [PID_W-1:0] i_create_pid,
  input  logic [PC_W-1:0]  i_create_pc,
  input  logic             i_yield,
  input  logic             i_exit,
  input  logic [PC_W-1:0]  i_current_pc,
  output logic             o_stall,
  output logic             o_pc_load,
  output logic [PC_W-1:0]  o_pc_load_value,
  output logic [PID_W-1:0] o_pid_cpu,
  output logic             o_running
);
  localparam int CNT_W = $clog2(QUANTUM) + 1;
  state_t            r_state, w_next;
  proc_entry_t       r_tbl [NUM_PROC];
  logic [CNT_W-1:0]  r_cnt;
  logic              r_exit_pend;
  logic [NUM_PROC-1:0] w_valid;
  logic              w_found, w_create_ok, w_event;
  logic [PID_W-1:0]  w_pick_pid;
  logic [PC_W-1:0]   w_pick_pc;
  assign w_create_ok = i_create_en && (32'(i_create_pid) < NUM_PROC);
  assign w_event = i_exit | i_yield | (r_cnt == CNT_W'(QUANTUM - 1));
  rr_pid_picker #(.NUM_PROC(NUM_PROC), .PID_W(PID_W)) u_picker (
    .i_valid (w_valid),
    .i_last  (o_pid_cpu),
    .o_found (w_found),
    .o_pid   (w_pick_pid)
  );
  // flatten valid bits and fetch the saved PC of the picked process
  always_comb begin
    w_valid = '0;
    w_pick_pc = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      w_valid[i] = r_tbl[i].valid;
      if (w_pick_pid == PID_W'(i)) w_pick_pc = r_tbl[i].pc;
    end
  end
  // next-state selection for the context-switch sequence
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   w_next = (|w_valid || w_create_ok) ? ST_SELECT : ST_IDLE;
      ST_RUN:    w_next = w_event ? ST_SAVE : ST_RUN;
      ST_SAVE:   w_next = ST_SELECT;
      ST_SELECT: w_next = w_found ? ST_LOAD : ST_IDLE;
      ST_LOAD:   w_next = ST_RUN;
      default:   w_next = ST_IDLE;
    endcase
  end
  // state, quantum counter and registered CPU-facing outputs derived from the next state
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_exit_pend <= 1'b0;
      o_stall <= 1'b1;
      o_pc_load <= 1'b0;
      o_pc_load_value <= '0;
      o_pid_cpu <= '0;
      o_running <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= (r_state == ST_LOAD) ? '0 : (r_state == ST_RUN) ? r_cnt + CNT_W'(1) : r_cnt;
      r_exit_pend <= (r_state == ST_RUN) ? i_exit : (r_state == ST_SAVE) ? 1'b0 : r_exit_pend;
      o_stall <= (w_next != ST_RUN);
      o_running <= (w_next == ST_RUN);
      o_pc_load <= (w_next == ST_LOAD);
      if (w_next == ST_LOAD) begin
        o_pid_cpu <= w_pick_pid;
        o_pc_load_value <= w_pick_pc;
      end
    end
  end
  // process table: save/exit of the current slot, with create taking precedence
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_PROC; i++) begin
      if (!i_rst_n) begin
        r_tbl[i] <= '0;
      end else begin
        if (r_state == ST_SAVE && o_pid_cpu == PID_W'(i)) begin
          if (r_exit_pend) r_tbl[i].valid <= 1'b0;
          else r_tbl[i].pc <= i_current_pc;
        end
        if (w_create_ok && i_create_pid == PID_W'(i)) r_tbl[i] <= '{valid: 1'b1, pc: i_create_pc};
      end
    end
  end
endmodule

// File: tb/tb_process_scheduler.sv
// tb_process_scheduler: directed checks of switching, yield, exit, create and reset
module tb_process_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        create_en = 1'b0;
  logic [4:0]  create_pid = '0;
  logic [31:0] create_pc = '0;
  logic        yield = 1'b0;
  logic        exit_p = 1'b0;
  logic [31:0] cpu_pc = '0;
  logic        stall, pc_load, running;
  logic [31:0] pc_load_value;
  logic [4:0]  pid_cpu;
  int n_chk = 0;
  int n_fail = 0;
  int rc, sc;
  process_scheduler #(.NUM_PROC(8), .PID_W(5), .PC_W(32), .QUANTUM(4)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_create_en     (create_en),
    .i_create_pid    (create_pid),
    .i_create_pc     (create_pc),
    .i_yield         (yield),
    .i_exit          (exit_p),
    .i_current_pc    (cpu_pc),
    .o_stall         (stall),
    .o_pc_load       (pc_load),
    .o_pc_load_value (pc_load_value),
    .o_pid_cpu       (pid_cpu),
    .o_running       (running)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic        ld = pc_load;
    logic        st = stall;
    logic [31:0] v = pc_load_value;
    @(posedge clk);
    #1;
    if (ld) cpu_pc = v;
    else if (!st) cpu_pc = cpu_pc + 1;
  endtask
  task automatic run_until_load(output int run_cyc, output int stall_cyc);
    int n = 0;
    run_cyc = 0;
    stall_cyc = 0;
    while (n < 50) begin
      tick();
      n++;
      if (running) run_cyc++;
      if (stall) stall_cyc++;
      if (pc_load) break;
    end
    if (n >= 50) check("load_timeout", 32'(n), 32'd0);
  endtask
  task automatic create(input logic [4:0] pid, input logic [31:0] pc);
    create_en = 1'b1;
    create_pid = pid;
    create_pc = pc;
    tick();
    create_en = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_pcload", 32'(pc_load), 32'd0);
    check("rst_pcval", pc_load_value, 32'd0);
    check("rst_pid", 32'(pid_cpu), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_stall", 32'(stall), 32'd1);
    create(5'd2, 32'h40);
    check("sel_pcload", 32'(pc_load), 32'd0);
    check("sel_stall", 32'(stall), 32'd1);
    tick();
    check("t1_pcload", 32'(pc_load), 32'd1);
    check("t1_pcval", pc_load_value, 32'h40);
    check("t1_pid", 32'(pid_cpu), 32'd2);
    check("t1_load_stall", 32'(stall), 32'd1);
    check("t1_load_run", 32'(running), 32'd0);
    tick();
    check("t1_running", 32'(running), 32'd1);
    check("t1_run_stall", 32'(stall), 32'd0);
    check("t1_pcload_pulse", 32'(pc_load), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    create(5'd9, 32'h99);
    tick();
    check("bad_pid_stall", 32'(stall), 32'd1);
    check("bad_pid_pcload", 32'(pc_load), 32'd0);
    check("bad_pid_running", 32'(running), 32'd0);
    create(5'd0, 32'h10);
    create(5'd1, 32'h80);
    check("t2_pid0_load", 32'(pid_cpu), 32'd0);
    check("t2_pid0_pc", pc_load_value, 32'h10);
    run_until_load(rc, sc);
    check("t2_run0", 32'(rc), 32'd4);
    check("t2_stall0", 32'(sc), 32'd3);
    check("t2_pid1", 32'(pid_cpu), 32'd1);
    check("t2_pc1", pc_load_value, 32'h80);
    run_until_load(rc, sc);
    check("t2_run1", 32'(rc), 32'd4);
    check("t2_stall1", 32'(sc), 32'd3);
    check("t2_pid0_back", 32'(pid_cpu), 32'd0);
    check("t2_pc0_saved", pc_load_value, 32'h14);
    tick();
    tick();
    yield = 1'b1;
    tick();
    yield = 1'b0;
    check("y_save_stall", 32'(stall), 32'd1);
    check("y_save_run", 32'(running), 32'd0);
    tick();
    tick();
    check("y_pid1", 32'(pid_cpu), 32'd1);
    check("y_pc1", pc_load_value, 32'h84);
    tick();
    exit_p = 1'b1;
    tick();
    exit_p = 1'b0;
    tick();
    tick();
    check("ex_pid0", 32'(pid_cpu), 32'd0);
    check("ex_pc0", pc_load_value, 32'h16);
    tick();
    yield = 1'b1;
    tick();
    yield = 1'b0;
    tick();
    tick();
    check("self_pid", 32'(pid_cpu), 32'd0);
    check("self_pc", pc_load_value, 32'h17);
    check("self_pcload", 32'(pc_load), 32'd1);
    tick();
    exit_p = 1'b1;
    tick();
    exit_p = 1'b0;
    tick();
    tick();
    check("last_exit_stall", 32'(stall), 32'd1);
    check("last_exit_pcload", 32'(pc_load), 32'd0);
    tick();
    check("idle_hold_pcload", 32'(pc_load), 32'd0);
    check("idle_hold_run", 32'(running), 32'd0);
    create(5'd5, 32'h200);
    tick();
    check("p5_pid", 32'(pid_cpu), 32'd5);
    check("p5_pc", pc_load_value, 32'h200);
    tick();
    exit_p = 1'b1;
    tick();
    exit_p = 1'b0;
    create(5'd5, 32'h300);
    tick();
    check("exit_create_pid", 32'(pid_cpu), 32'd5);
    check("exit_create_pc", pc_load_value, 32'h300);
    check("exit_create_load", 32'(pc_load), 32'd1);
    tick();
    yield = 1'b1;
    tick();
    yield = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_stall", 32'(stall), 32'd1);
    check("mid_rst_pcload", 32'(pc_load), 32'd0);
    check("mid_rst_pcval", pc_load_value, 32'd0);
    check("mid_rst_pid", 32'(pid_cpu), 32'd0);
    check("mid_rst_run", 32'(running), 32'd0);
    tick();
    tick();
    tick();
    check("mid_rst_empty_pcload", 32'(pc_load), 32'd0);
    check("mid_rst_empty_stall", 32'(stall), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
